scoot_move_arbiter: RTL and testbench

SCOOT_MOVE_ARBITER -- requirements
Module: scoot_move_arbiter

---
 rtl/scoot_move_arbiter_if.sv | 32 +++
 rtl/scoot_move_arbiter.sv | 177 +++++++++++++++++
 tb/tb_scoot_move_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/scoot_move_arbiter_if.sv
// Bus between the move arbiter and its bots / pellet grid.
// The slave modport is the arbiter side; the master modport is the environment side.
interface scoot_move_arbiter_if #(
    parameter int NUM_BOTS = 4,
    parameter int CW       = 4
);
    logic [NUM_BOTS-1:0]    reqValid;
    logic [4*NUM_BOTS-1:0]  reqDir;
    logic [NUM_BOTS-1:0]    reqAck;
    logic                   reqBlocked;
    logic                   gridRead;
    logic [CW-1:0]          gridX;
    logic [CW-1:0]          gridY;
    logic                   pelletIn;
    logic                   pelletClear;
    logic [CW*NUM_BOTS-1:0] botX;
    logic [CW*NUM_BOTS-1:0] botY;
    logic [7:0]             pickups;
    logic                   busy;

    modport master (
        output reqValid, reqDir, pelletIn,
        input  reqAck, reqBlocked, gridRead, gridX, gridY, pelletClear,
               botX, botY, pickups, busy
    );

    modport slave (
        input  reqValid, reqDir, pelletIn,
        output reqAck, reqBlocked, gridRead, gridX, gridY, pelletClear,
               botX, botY, pickups, busy
    );
endinterface

// File: rtl/scoot_move_arbiter.sv
// Round-robin arbiter serialising bot moves on a wrapping grid: one move per
// IDLE -> LOOKUP -> COMMIT pass, with collision blocking and pellet pickup.
module scoot_move_arbiter #(
    parameter int NUM_BOTS = 4,
    parameter int WIDTH    = 10,
    parameter int HEIGHT   = 10,
    parameter int CW       = 4
) (
    input  logic                clock,
    input  logic                resetN,
    scoot_move_arbiter_if.slave bus
);
    localparam int IW = (NUM_BOTS > 1) ? $clog2(NUM_BOTS) : 1;
    localparam logic [CW-1:0] X_MAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] Y_MAX = CW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        COMMIT = 2'd2
    } state_t;

    function automatic logic is_onehot4(input logic [3:0] d);
        return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
    endfunction

    // One step along an axis that wraps between 0 and p_max.
    function automatic logic [CW-1:0] step_pos(input logic [CW-1:0] p, input logic [CW-1:0] p_max,
                                               input logic inc, input logic dec);
        logic [CW-1:0] q;
        if (inc) begin
            q = (p == p_max) ? {CW{1'b0}} : p + {{(CW-1){1'b0}}, 1'b1};
        end else if (dec) begin
            q = (p == {CW{1'b0}}) ? p_max : p - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            q = p;
        end
        return q;
    endfunction

    state_t                 r_state;
    logic [IW-1:0]          r_rr_ptr;
    logic [IW-1:0]          r_gnt;
    logic                   r_move_blk;
    logic [NUM_BOTS-1:0]    r_ack;
    logic                   r_blocked;
    logic                   r_grid_read;
    logic [CW-1:0]          r_grid_x;
    logic [CW-1:0]          r_grid_y;
    logic                   r_pellet_clear;
    logic [CW*NUM_BOTS-1:0] r_bot_x;
    logic [CW*NUM_BOTS-1:0] r_bot_y;
    logic [7:0]             r_pickups;
    logic                   r_busy;

    logic                   w_any;
    logic [IW-1:0]          w_gnt;
    logic [3:0]             w_dir;
    logic [CW-1:0]          w_cur_x;
    logic [CW-1:0]          w_cur_y;
    logic [CW-1:0]          w_dest_x;
    logic [CW-1:0]          w_dest_y;
    logic                   w_hit;
    logic                   w_blocked;

    // Grant selection, destination and collision check for the move decided in IDLE.
    always_comb begin
        w_any   = |bus.reqValid;
        w_gnt   = {IW{1'b0}};
        w_dir   = 4'd0;
        w_cur_x = {CW{1'b0}};
        w_cur_y = {CW{1'b0}};
        w_hit   = 1'b0;
        // Walking offsets downward lets the smallest offset from rrPtr win.
        for (int k = NUM_BOTS - 1; k >= 0; k--) begin
            w_gnt = bus.reqValid[IW'((int'(r_rr_ptr) + k) % NUM_BOTS)]
                  ? IW'((int'(r_rr_ptr) + k) % NUM_BOTS) : w_gnt;
        end
        for (int k = 0; k < NUM_BOTS; k++) begin
            w_dir   = (w_gnt == IW'(k)) ? bus.reqDir[4*k +: 4]  : w_dir;
            w_cur_x = (w_gnt == IW'(k)) ? r_bot_x[CW*k +: CW] : w_cur_x;
            w_cur_y = (w_gnt == IW'(k)) ? r_bot_y[CW*k +: CW] : w_cur_y;
        end
        w_dest_x = step_pos(w_cur_x, X_MAX, w_dir[1], w_dir[3]);
        w_dest_y = step_pos(w_cur_y, Y_MAX, w_dir[0], w_dir[2]);
        for (int k = 0; k < NUM_BOTS; k++) begin
            w_hit = w_hit | ((w_gnt != IW'(k)) &&
                             (r_bot_x[CW*k +: CW] == w_dest_x) &&
                             (r_bot_y[CW*k +: CW] == w_dest_y));
        end
        w_blocked = !is_onehot4(w_dir) || w_hit;
    end

    // Move FSM with all outputs registered.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state        <= IDLE;
            r_rr_ptr       <= {IW{1'b0}};
            r_gnt          <= {IW{1'b0}};
            r_move_blk     <= 1'b0;
            r_ack          <= {NUM_BOTS{1'b0}};
            r_blocked      <= 1'b0;
            r_grid_read    <= 1'b0;
            r_grid_x       <= {CW{1'b0}};
            r_grid_y       <= {CW{1'b0}};
            r_pellet_clear <= 1'b0;
            r_pickups      <= 8'd0;
            r_busy         <= 1'b0;
            for (int k = 0; k < NUM_BOTS; k++) begin
                r_bot_x[CW*k +: CW] <= CW'(k % WIDTH);
                r_bot_y[CW*k +: CW] <= CW'(HEIGHT / 2);
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state     <= LOOKUP;
                        r_gnt       <= w_gnt;
                        r_rr_ptr    <= (w_gnt == IW'(NUM_BOTS - 1)) ? {IW{1'b0}}
                                                                     : w_gnt + {{(IW-1){1'b0}}, 1'b1};
                        r_move_blk  <= w_blocked;
                        r_grid_read <= !w_blocked;
                        r_grid_x    <= w_dest_x;
                        r_grid_y    <= w_dest_y;
                        r_busy      <= 1'b1;
                    end else begin
                        r_busy      <= 1'b0;
                    end
                end
                LOOKUP: begin
                    r_state        <= COMMIT;
                    r_grid_read    <= 1'b0;
                    r_ack          <= {{(NUM_BOTS-1){1'b0}}, 1'b1} << r_gnt;
                    r_blocked      <= r_move_blk;
                    r_pellet_clear <= !r_move_blk && bus.pelletIn;
                end
                COMMIT: begin
                    r_state        <= IDLE;
                    r_ack          <= {NUM_BOTS{1'b0}};
                    r_blocked      <= 1'b0;
                    r_pellet_clear <= 1'b0;
                    r_busy         <= 1'b0;
                    if (!r_move_blk) begin
                        for (int k = 0; k < NUM_BOTS; k++) begin
                            if (r_gnt == IW'(k)) begin
                                r_bot_x[CW*k +: CW] <= r_grid_x;
                                r_bot_y[CW*k +: CW] <= r_grid_y;
                            end
                        end
                    end
                    if (r_pellet_clear && (r_pickups != 8'd255)) begin
                        r_pickups <= r_pickups + 8'd1;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_ack          <= {NUM_BOTS{1'b0}};
                    r_blocked      <= 1'b0;
                    r_grid_read    <= 1'b0;
                    r_pellet_clear <= 1'b0;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.reqAck      = r_ack;
    assign bus.reqBlocked  = r_blocked;
    assign bus.gridRead    = r_grid_read;
    assign bus.gridX       = r_grid_x;
    assign bus.gridY       = r_grid_y;
    assign bus.pelletClear = r_pellet_clear;
    assign bus.botX        = r_bot_x;
    assign bus.botY        = r_bot_y;
    assign bus.pickups     = r_pickups;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_scoot_move_arbiter.sv
// Directed bench for scoot_move_arbiter: a table of single moves with hand-computed
// results, then hand-written round-robin, saturation and reset-abort sequences.
module tb_scoot_move_arbiter;
    logic clk;
    logic rst_n;
    int   n_err;
    int   n_checks;

    scoot_move_arbiter_if #(.NUM_BOTS(4), .CW(4)) bus ();

    scoot_move_arbiter #(.NUM_BOTS(4), .WIDTH(10), .HEIGHT(10), .CW(4)) dut (
        .clock  (clk),
        .resetN (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       bot;
        logic [3:0] dir;
        bit       pel;
        bit       blk;
        int       gx;
        int       gy;
        int       ex;
        int       ey;
        int       pick;
    } vec_t;

    vec_t vecs [19];

    localparam logic [3:0] UP = 4'b0001, RT = 4'b0010, DN = 4'b0100, LT = 4'b1000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] nib(input logic [15:0] v, input int i);
        logic [15:0] t;
        t = v >> (4 * i);
        return t[3:0];
    endfunction

    task automatic quick_move(input int bot, input logic [3:0] dir, input bit pel, output bit got);
        got = 1'b0;
        @(negedge clk);
        bus.reqValid = 4'b0001 << bot;
        bus.reqDir   = {12'd0, dir} << (4 * bot);
        bus.pelletIn = pel;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.reqAck != 4'd0) begin
                got = 1'b1;
                break;
            end
        end
        bus.reqValid = 4'd0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        logic [3:0] exp_ack;
        n_err = 0;
        n_checks = 0;

        //          bot dir pel blk gx gy ex ey pick
        vecs[0]  = '{1, UP, 1'b0, 1'b0, 1, 6, 1, 6, 0};
        vecs[1]  = '{0, RT, 1'b1, 1'b0, 1, 5, 1, 5, 1};
        vecs[2]  = '{0, LT, 1'b0, 1'b0, 0, 5, 0, 5, 1};
        vecs[3]  = '{1, DN, 1'b1, 1'b0, 1, 5, 1, 5, 2};
        vecs[4]  = '{1, LT, 1'b1, 1'b1, 0, 0, 1, 5, 2};
        vecs[5]  = '{2, 4'b0011, 1'b0, 1'b1, 0, 0, 2, 5, 2};
        vecs[6]  = '{2, 4'b0000, 1'b0, 1'b1, 0, 0, 2, 5, 2};
        vecs[7]  = '{2, UP, 1'b0, 1'b0, 2, 6, 2, 6, 2};
        vecs[8]  = '{1, UP, 1'b0, 1'b0, 1, 6, 1, 6, 2};
        vecs[9]  = '{0, UP, 1'b0, 1'b0, 0, 6, 0, 6, 2};
        vecs[10] = '{3, LT, 1'b1, 1'b0, 2, 5, 2, 5, 3};
        vecs[11] = '{3, LT, 1'b0, 1'b0, 1, 5, 1, 5, 3};
        vecs[12] = '{3, LT, 1'b0, 1'b0, 0, 5, 0, 5, 3};
        vecs[13] = '{3, LT, 1'b0, 1'b0, 9, 5, 9, 5, 3};
        vecs[14] = '{2, UP, 1'b0, 1'b0, 2, 7, 2, 7, 3};
        vecs[15] = '{2, UP, 1'b0, 1'b0, 2, 8, 2, 8, 3};
        vecs[16] = '{2, UP, 1'b0, 1'b0, 2, 9, 2, 9, 3};
        vecs[17] = '{2, UP, 1'b0, 1'b0, 2, 0, 2, 0, 3};
        vecs[18] = '{2, DN, 1'b0, 1'b0, 2, 9, 2, 9, 3};

        bus.reqValid = 4'd0;
        bus.reqDir   = 16'd0;
        bus.pelletIn = 1'b0;
        rst_n = 1'b0;
        #12;
        check("rst_botX", 32'(bus.botX), 32'h3210);
        check("rst_botY", 32'(bus.botY), 32'h5555);
        check("rst_pickups", 32'(bus.pickups), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ack", 32'(bus.reqAck), 32'd0);
        check("rst_gridRead", 32'(bus.gridRead), 32'd0);
        check("rst_pelletClear", 32'(bus.pelletClear), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 19; v++) begin
            @(negedge clk);
            bus.reqValid = 4'b0001 << vecs[v].bot;
            bus.reqDir   = {12'd0, vecs[v].dir} << (4 * vecs[v].bot);
            bus.pelletIn = vecs[v].pel;
            @(negedge clk);
            bus.reqValid = 4'd0;
            check($sformatf("v%0d_lookup_busy", v), 32'(bus.busy), 32'd1);
            check($sformatf("v%0d_lookup_ack", v), 32'(bus.reqAck), 32'd0);
            check($sformatf("v%0d_gridRead", v), 32'(bus.gridRead), 32'(!vecs[v].blk));
            if (!vecs[v].blk) begin
                check($sformatf("v%0d_gridX", v), 32'(bus.gridX), vecs[v].gx);
                check($sformatf("v%0d_gridY", v), 32'(bus.gridY), vecs[v].gy);
            end
            @(negedge clk);
            check($sformatf("v%0d_ack", v), 32'(bus.reqAck), 32'(4'b0001 << vecs[v].bot));
            check($sformatf("v%0d_blocked", v), 32'(bus.reqBlocked), 32'(vecs[v].blk));
            check($sformatf("v%0d_pelletClear", v), 32'(bus.pelletClear),
                  32'(vecs[v].pel && !vecs[v].blk));
            check($sformatf("v%0d_commit_gridRead", v), 32'(bus.gridRead), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_x", v), 32'(nib(bus.botX, vecs[v].bot)), vecs[v].ex);
            check($sformatf("v%0d_y", v), 32'(nib(bus.botY, vecs[v].bot)), vecs[v].ey);
            check($sformatf("v%0d_pickups", v), 32'(bus.pickups), vecs[v].pick);
            check($sformatf("v%0d_idle_ack", v), 32'(bus.reqAck), 32'd0);
            check($sformatf("v%0d_idle_busy", v), 32'(bus.busy), 32'd0);
        end

        // Round robin with all four bots requesting up continuously.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.reqValid = 4'hF;
        bus.reqDir   = 16'h1111;
        bus.pelletIn = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            exp_ack = (c % 3 == 1) ? (4'b0001 << ((c / 3) % 4)) : 4'd0;
            check($sformatf("rr_c%0d_ack", c), 32'(bus.reqAck), 32'(exp_ack));
            check($sformatf("rr_c%0d_busy", c), 32'(bus.busy), 32'(c % 3 != 2));
            if (c == 14) bus.reqValid = 4'd0;
        end
        check("rr_botX", 32'(bus.botX), 32'h3210);
        check("rr_botY", 32'(bus.botY), 32'h6667);

        // Pickup saturation: bot 0 shuttles between (0,8) and (0,7) on pellets.
        for (int i = 0; i < 260; i++) begin
            quick_move(0, (i % 2 == 0) ? UP : DN, 1'b1, got);
            check($sformatf("sat_ack_%0d", i), 32'(got), 32'd1);
            if (i == 253 || i == 254 || i == 259) begin
                check($sformatf("sat_pickups_%0d", i), 32'(bus.pickups), 32'((i + 1 > 255) ? 255 : i + 1));
            end
        end
        check("sat_bot0_y", 32'(nib(bus.botY, 0)), 32'd7);

        // Reset asserted during COMMIT aborts the move.
        quick_move(3, RT, 1'b0, got);
        check("pre_rst_ack", 32'(got), 32'd1);
        check("pre_rst_bot3_x", 32'(nib(bus.botX, 3)), 32'd4);
        @(negedge clk);
        bus.reqValid = 4'b0100;
        bus.reqDir   = 16'h0100;
        bus.pelletIn = 1'b1;
        @(negedge clk);
        check("mid_gridRead", 32'(bus.gridRead), 32'd1);
        @(negedge clk);
        check("mid_commit_ack", 32'(bus.reqAck), 32'h4);
        check("mid_commit_pelletClear", 32'(bus.pelletClear), 32'd1);
        #1;
        rst_n = 1'b0;
        bus.reqValid = 4'd0;
        #1;
        check("abort_ack", 32'(bus.reqAck), 32'd0);
        check("abort_blocked", 32'(bus.reqBlocked), 32'd0);
        check("abort_pelletClear", 32'(bus.pelletClear), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_pickups", 32'(bus.pickups), 32'd0);
        check("abort_botX", 32'(bus.botX), 32'h3210);
        check("abort_botY", 32'(bus.botY), 32'h5555);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.reqValid = 4'hF;
        bus.reqDir   = 16'h1111;
        bus.pelletIn = 1'b0;
        got = 1'b0;
        exp_ack = 4'd0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.reqAck != 4'd0) begin
                got = 1'b1;
                exp_ack = bus.reqAck;
                break;
            end
        end
        bus.reqValid = 4'd0;
        check("post_rst_ack_seen", 32'(got), 32'd1);
        check("post_rst_rr_grant", 32'(exp_ack), 32'h1);
        @(negedge clk);
        check("post_rst_bot0_y", 32'(nib(bus.botY, 0)), 32'd6);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
